// File: rtl/dual_output_checker.sv
// Compares the output buses of two implementations driven by the same stimulus,
// once that stimulus has been stable for SETTLE_CYC cycles; counts checks/errors and keeps the first failure.
//
// state   | meaning
// IDLE    | no compare pending (stim already checked, or checking disabled)
// SETTLE  | stim changed, counting down the settle time
// COMPARE | next edge samples resp_a/resp_b unless stim moves again
module dual_output_checker #(
    parameter int IN_W       = 3,
    parameter int OUT_W      = 2,
    parameter int SETTLE_CYC = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [IN_W-1:0]  stim,
    input  logic [OUT_W-1:0] resp_a,
    input  logic [OUT_W-1:0] resp_b,
    output logic             busy,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] check_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [IN_W-1:0]  first_stim,
    output logic [OUT_W-1:0] first_a,
    output logic [OUT_W-1:0] first_b
);

    typedef enum logic [1:0] {IDLE, SETTLE, COMPARE} state_t;

    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t          state;
    logic [IN_W-1:0] last_stim;
    logic            armed;
    logic [7:0]      settle_cnt;
    logic            trigger;

    // An unarmed checker always restarts, so re-enabling forces a fresh compare.
    assign trigger = en && (!armed || (stim != last_stim));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            mismatch   <= 1'b0;
            err_sticky <= 1'b0;
            check_cnt  <= '0;
            err_cnt    <= '0;
            first_stim <= '0;
            first_a    <= '0;
            first_b    <= '0;
            last_stim  <= '0;
            armed      <= 1'b0;
            settle_cnt <= '0;
        end else begin
            mismatch <= 1'b0;
            if (clr) begin
                state      <= IDLE;
                busy       <= 1'b0;
                err_sticky <= 1'b0;
                check_cnt  <= '0;
                err_cnt    <= '0;
                first_stim <= '0;
                first_a    <= '0;
                first_b    <= '0;
                armed      <= 1'b0;
            end else if (!en) begin
                state <= IDLE;
                busy  <= 1'b0;
                armed <= 1'b0;
            end else if (trigger) begin
                state      <= SETTLE;
                busy       <= 1'b1;
                settle_cnt <= SETTLE_LOAD;
                last_stim  <= stim;
                armed      <= 1'b1;
            end else begin
                case (state)
                    SETTLE: begin
                        if (settle_cnt != 8'd0)
                            settle_cnt <= settle_cnt - 8'd1;
                        else
                            state <= COMPARE;
                    end
                    COMPARE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (check_cnt != CNT_MAX)
                            check_cnt <= check_cnt + 1'b1;
                        if (resp_a != resp_b) begin
                            mismatch   <= 1'b1;
                            err_sticky <= 1'b1;
                            if (err_cnt != CNT_MAX)
                                err_cnt <= err_cnt + 1'b1;
                            if (!err_sticky) begin
                                first_stim <= last_stim;
                                first_a    <= resp_a;
                                first_b    <= resp_b;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dual_output_checker.sv
// Bench for dual_output_checker: two instances (settle 4 / 8-bit counters, settle 1 / 2-bit counters)
// share one stimulus and are checked each cycle against a deadline-based reference model.
module tb_dual_output_checker;

    logic       clk = 1'b0;
    logic       rst_n, en, clr;
    logic [2:0] stim;
    logic [1:0] resp_a, resp_b;

    logic       busy0, mismatch0, sticky0;
    logic [7:0] check_cnt0, err_cnt0;
    logic [2:0] first_stim0;
    logic [1:0] first_a0, first_b0;

    logic       busy1, mismatch1, sticky1;
    logic [1:0] check_cnt1, err_cnt1;
    logic [2:0] first_stim1;
    logic [1:0] first_a1, first_b1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dual_output_checker #(.IN_W(3), .OUT_W(2), .SETTLE_CYC(4), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .stim(stim),
        .resp_a(resp_a), .resp_b(resp_b),
        .busy(busy0), .mismatch(mismatch0), .err_sticky(sticky0),
        .check_cnt(check_cnt0), .err_cnt(err_cnt0),
        .first_stim(first_stim0), .first_a(first_a0), .first_b(first_b0)
    );

    dual_output_checker #(.IN_W(3), .OUT_W(2), .SETTLE_CYC(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .stim(stim),
        .resp_a(resp_a), .resp_b(resp_b),
        .busy(busy1), .mismatch(mismatch1), .err_sticky(sticky1),
        .check_cnt(check_cnt1), .err_cnt(err_cnt1),
        .first_stim(first_stim1), .first_a(first_a1), .first_b(first_b1)
    );

    // Reference model: each lane remembers the edge number at which its compare is due.
    localparam int SET  [2] = '{4, 1};
    localparam int MAXC [2] = '{255, 3};

    int         cyc_n = 0;
    int         m_due    [2];
    logic       m_armed  [2];
    logic [2:0] m_last   [2];
    int         m_chk    [2];
    int         m_err    [2];
    logic       m_sticky [2];
    logic       m_mis    [2];
    logic [2:0] m_fs     [2];
    logic [1:0] m_fa     [2];
    logic [1:0] m_fb     [2];

    always @(posedge clk) begin
        cyc_n++;
        for (int k = 0; k < 2; k++) begin
            m_mis[k] = 1'b0;
            if (!rst_n) begin
                m_due[k] = -1; m_armed[k] = 1'b0; m_last[k] = '0;
                m_chk[k] = 0;  m_err[k] = 0;      m_sticky[k] = 1'b0;
                m_fs[k] = '0;  m_fa[k] = '0;      m_fb[k] = '0;
            end else if (clr) begin
                m_due[k] = -1; m_armed[k] = 1'b0;
                m_chk[k] = 0;  m_err[k] = 0;      m_sticky[k] = 1'b0;
                m_fs[k] = '0;  m_fa[k] = '0;      m_fb[k] = '0;
            end else if (!en) begin
                m_due[k] = -1; m_armed[k] = 1'b0;
            end else if (!m_armed[k] || stim != m_last[k]) begin
                m_due[k]   = cyc_n + SET[k] + 1;
                m_last[k]  = stim;
                m_armed[k] = 1'b1;
            end else if (m_due[k] == cyc_n) begin
                m_due[k] = -1;
                if (m_chk[k] < MAXC[k]) m_chk[k]++;
                if (resp_a != resp_b) begin
                    if (m_err[k] < MAXC[k]) m_err[k]++;
                    m_mis[k] = 1'b1;
                    if (!m_sticky[k]) begin
                        m_fs[k] = m_last[k]; m_fa[k] = resp_a; m_fb[k] = resp_b;
                    end
                    m_sticky[k] = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("busy0",       32'(busy0),       32'(m_due[0] >= 0));
        chk("mismatch0",   32'(mismatch0),   32'(m_mis[0]));
        chk("sticky0",     32'(sticky0),     32'(m_sticky[0]));
        chk("check_cnt0",  32'(check_cnt0),  32'(m_chk[0]));
        chk("err_cnt0",    32'(err_cnt0),    32'(m_err[0]));
        chk("first_stim0", 32'(first_stim0), 32'(m_fs[0]));
        chk("first_a0",    32'(first_a0),    32'(m_fa[0]));
        chk("first_b0",    32'(first_b0),    32'(m_fb[0]));
        chk("busy1",       32'(busy1),       32'(m_due[1] >= 0));
        chk("mismatch1",   32'(mismatch1),   32'(m_mis[1]));
        chk("sticky1",     32'(sticky1),     32'(m_sticky[1]));
        chk("check_cnt1",  32'(check_cnt1),  32'(m_chk[1]));
        chk("err_cnt1",    32'(err_cnt1),    32'(m_err[1]));
        chk("first_stim1", 32'(first_stim1), 32'(m_fs[1]));
        chk("first_a1",    32'(first_a1),    32'(m_fa[1]));
        chk("first_b1",    32'(first_b1),    32'(m_fb[1]));
    endtask

    // Inputs change just after the falling edge, outputs are judged on it.
    task automatic cyc();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; stim = '0; resp_a = '0; resp_b = '0;
        repeat (3) cyc();
        chk("rst_busy",  32'(busy0), 0);
        chk("rst_cnt",   32'(check_cnt0), 0);
        chk("rst_fstim", 32'(first_stim0), 0);

        rst_n = 1'b1; en = 1'b1; stim = 3'b000; resp_a = 2'b01; resp_b = 2'b01;
        repeat (5) cyc();
        chk("pre_cmp_busy", 32'(busy0), 1);
        chk("pre_cmp_cnt",  32'(check_cnt0), 0);
        cyc();
        chk("cmp_cnt",  32'(check_cnt0), 1);
        chk("cmp_err",  32'(err_cnt0), 0);
        chk("cmp_busy", 32'(busy0), 0);

        stim = 3'b101; resp_a = 2'b10; resp_b = 2'b11;
        repeat (6) cyc();
        chk("mis_pulse", 32'(mismatch0), 1);
        chk("mis_err",   32'(err_cnt0), 1);
        chk("mis_stick", 32'(sticky0), 1);
        chk("cap_stim",  32'(first_stim0), 32'h5);
        chk("cap_a",     32'(first_a0), 32'h2);
        chk("cap_b",     32'(first_b0), 32'h3);
        stim = 3'b110;
        cyc();
        chk("mis_width", 32'(mismatch0), 0);
        repeat (5) cyc();
        chk("mis2_err",  32'(err_cnt0), 2);
        chk("cap2_stim", 32'(first_stim0), 32'h5);

        resp_a = 2'b00; resp_b = 2'b00;
        stim = 3'b001; cyc();
        stim = 3'b011; cyc();
        stim = 3'b001; cyc();
        repeat (4) cyc();
        chk("glitch_pre", 32'(check_cnt0), 3);
        cyc();
        chk("glitch_cnt", 32'(check_cnt0), 4);

        stim = 3'b010;
        repeat (2) cyc();
        en = 1'b0;
        repeat (3) cyc();
        chk("en_low_cnt",  32'(check_cnt0), 4);
        chk("en_low_busy", 32'(busy0), 0);
        en = 1'b1;
        repeat (6) cyc();
        chk("reen_cnt", 32'(check_cnt0), 5);
        clr = 1'b1; cyc(); clr = 1'b0;
        chk("clr_cnt",    32'(check_cnt0), 0);
        chk("clr_err",    32'(err_cnt0), 0);
        chk("clr_sticky", 32'(sticky0), 0);
        chk("clr_fstim",  32'(first_stim0), 0);

        resp_a = 2'b01; resp_b = 2'b10;
        for (int i = 0; i < 5; i++) begin
            stim = 3'(i);
            repeat (6) cyc();
            chk("sat_pulse", 32'(mismatch0), 1);
        end
        chk("sat_chk1", 32'(check_cnt1), 3);
        chk("sat_err1", 32'(err_cnt1), 3);
        chk("sat_chk0", 32'(check_cnt0), 5);
        chk("sat_err0", 32'(err_cnt0), 5);

        resp_a = 2'b00; resp_b = 2'b00; stim = 3'b111;
        repeat (4) cyc();
        rst_n = 1'b0;
        cyc();
        chk("rst_mid_busy", 32'(busy0), 0);
        chk("rst_mid_cnt",  32'(check_cnt0), 0);
        rst_n = 1'b1;

        repeat (3000) begin
            rst_n  = ($urandom_range(0, 299) != 0);
            clr    = ($urandom_range(0, 149) == 0);
            en     = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 5) == 0) stim = 3'($urandom);
            resp_a = 2'($urandom);
            resp_b = ($urandom_range(0, 1) == 0) ? resp_a : 2'($urandom);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
